// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package adder_pkg;

   // Encoding 2'd3 is unused; the controller steers it back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder slice (combinational).
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through a single full-adder
// slice with a registered carry.
//
// Handshake: start is sampled only while idle (busy=0, done=0). The edge that
// sees start=1 in IDLE captures a/b/cin and raises busy for WIDTH cycles.
// done then pulses for exactly one cycle, and from that cycle sum/cout hold
// the new result until the next operation finishes. start is ignored while
// busy or done is high. fsm_state mirrors the controller state for debug.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       fsm_state
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] partial_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;

   fulladder u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // The new sum bit enters at the MSB; after WIDTH shifts bit 0 lands at partial[0].
   assign partial_nx = WIDTH'({fa_sum, partial} >> 1);
   assign last_bit   = (cnt == CNT_LAST);
   assign fsm_state  = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state and status decode; unused encodings fall back to IDLE.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_SHIFT;
         S_SHIFT: begin
            busy = 1'b1;
            if (last_bit) state_nx = S_DONE;
         end
         S_DONE:  begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Operand capture, per-bit shift/add, and result update on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a    <= '0;
         sh_b    <= '0;
         partial <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sh_a    <= a;
                  sh_b    <= b;
                  carry   <= cin;
                  cnt     <= '0;
                  partial <= '0;
               end
            end
            S_SHIFT: begin
               sh_a    <= sh_a >> 1;
               sh_b    <= sh_b >> 1;
               partial <= partial_nx;
               carry   <= fa_cout;
               cnt     <= cnt + 1'b1;
               if (last_bit) begin
                  sum  <= partial_nx;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       busy, done, cout;
   logic [7:0] sum;
   logic [1:0] st;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;
   logic [1:0] st1;

   int vectors = 0;
   int miscompares = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .fsm_state(st)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .fsm_state(st1)
   );

   // Clock: posedge at 5,15,...; inputs driven and outputs sampled on negedges.
   always #5 clk = ~clk;

   // Driver: pulse start with operands, optionally disturb inputs mid-operation,
   // and wait (bounded) for done. lat counts negedges from start drive to done
   // (0 = timed out); moved flags any sum/cout change before done.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input bit disturb, output int lat, output int nbusy,
                       output logic [7:0] rs, output logic rc, output bit moved);
      logic [7:0] s0;
      logic       c0;
      lat = 0; nbusy = 0; moved = 1'b0; rs = '0; rc = 1'b0;
      @(negedge clk);
      s0 = sum; c0 = cout;
      a = ia; b = ib; cin = ic; start = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
         end
         if (disturb && i == 3) begin
            a = 8'h00; b = 8'h00; cin = 1'b0; start = 1'b1;
         end
         if (disturb && i == 4) start = 1'b0;
         if (busy) nbusy++;
         if (done) begin
            lat = i; rs = sum; rc = cout;
            break;
         end
         if (sum !== s0 || cout !== c0) moved = 1'b1;
      end
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || st !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b st=%0d, want 0 0 00 0 0",
                  busy, done, sum, cout, st);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || st !== 2'd0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy=%b done=%b st=%0d, want 0 0 0", busy, done, st);
      end
   endtask

   task automatic test_basic();
      int lat, nbusy; logic [7:0] rs; logic rc; bit moved;
      run8(8'h3C, 8'h5A, 1'b0, 1'b0, lat, nbusy, rs, rc, moved);
      vectors++;
      if (lat != 9 || nbusy != 8) begin
         miscompares++;
         $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, want 9 8", lat, nbusy);
      end
      vectors++;
      if (rs !== 8'h96 || rc !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_result: sum=%h cout=%b, want 96 0", rs, rc);
      end
      vectors++;
      if (moved) begin
         miscompares++;
         $display("FAIL basic_hold: sum/cout changed before done, want stable");
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96 || st !== 2'd0) begin
         miscompares++;
         $display("FAIL basic_after: done=%b busy=%b sum=%h st=%0d, want 0 0 96 0", done, busy, sum, st);
      end
   endtask

   task automatic test_carry();
      int lat, nbusy; logic [7:0] rs; logic rc; bit moved;
      run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, nbusy, rs, rc, moved);
      vectors++;
      if (lat != 9 || rs !== 8'h00 || rc !== 1'b1 || moved) begin
         miscompares++;
         $display("FAIL carry_ff_01: lat=%0d sum=%h cout=%b moved=%b, want 9 00 1 0", lat, rs, rc, moved);
      end
      run8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, nbusy, rs, rc, moved);
      vectors++;
      if (lat != 9 || rs !== 8'hFF || rc !== 1'b1 || moved) begin
         miscompares++;
         $display("FAIL carry_ff_ff_1: lat=%0d sum=%h cout=%b moved=%b, want 9 ff 1 0", lat, rs, rc, moved);
      end
   endtask

   task automatic test_back_to_back();
      int ndone = 0, first = 0, last = 0, bad_sum = 0;
      @(negedge clk);
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first == 0) first = i;
            last = i;
            if (sum !== 8'h03 || cout !== 1'b0) bad_sum++;
         end
      end
      start = 1'b0;
      vectors++;
      if (ndone != 3 || first != 9 || last != 29) begin
         miscompares++;
         $display("FAIL b2b_accepts: dones=%0d first=%0d last=%0d, want 3 9 29", ndone, first, last);
      end
      vectors++;
      if (bad_sum != 0) begin
         miscompares++;
         $display("FAIL b2b_result: %0d dones had wrong sum/cout, want 0 (sum 03 cout 0)", bad_sum);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || st !== 2'd0) begin
         miscompares++;
         $display("FAIL b2b_stop: busy=%b st=%0d, want 0 0", busy, st);
      end
   endtask

   task automatic test_ignore_start();
      int lat, nbusy, extra = 0; logic [7:0] rs; logic rc; bit moved;
      run8(8'h80, 8'h80, 1'b1, 1'b1, lat, nbusy, rs, rc, moved);
      vectors++;
      if (lat != 9 || rs !== 8'h01 || rc !== 1'b1) begin
         miscompares++;
         $display("FAIL ignore_result: lat=%0d sum=%h cout=%b, want 9 01 1", lat, rs, rc);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL ignore_requeue: %0d busy/done cycles after done, want 0", extra);
      end
   endtask

   task automatic test_async_reset();
      int lat, nbusy, stray = 0; logic [7:0] rs; logic rc; bit moved;
      @(negedge clk);
      a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || st !== 2'd1) begin
         miscompares++;
         $display("FAIL rst_pre: busy=%b st=%0d, want 1 1", busy, st);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || st !== 2'd0) begin
         miscompares++;
         $display("FAIL rst_async: busy=%b done=%b sum=%h cout=%b st=%0d, want 0 0 00 0 0",
                  busy, done, sum, cout, st);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy || done) stray++;
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL rst_no_done: %0d busy/done cycles after abort, want 0", stray);
      end
      run8(8'h7F, 8'h01, 1'b1, 1'b0, lat, nbusy, rs, rc, moved);
      vectors++;
      if (lat != 9 || rs !== 8'h81 || rc !== 1'b0 || moved) begin
         miscompares++;
         $display("FAIL rst_recover: lat=%0d sum=%h cout=%b moved=%b, want 9 81 0 0", lat, rs, rc, moved);
      end
   endtask

   task automatic test_width1();
      logic [2:0] vec [2] = '{3'b111, 3'b100};
      logic [1:0] want [2] = '{2'b11, 2'b01};
      for (int v = 0; v < 2; v++) begin
         int lat = 0, nbusy = 0;
         logic [1:0] got = '0;
         @(negedge clk);
         a1 = vec[v][2]; b1 = vec[v][1]; cin1 = vec[v][0]; start1 = 1'b1;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) start1 = 1'b0;
            if (busy1) nbusy++;
            if (done1) begin
               lat = i; got = {cout1, sum1};
               break;
            end
         end
         vectors++;
         if (lat != 2 || nbusy != 1 || got !== want[v]) begin
            miscompares++;
            $display("FAIL width1_v%0d: lat=%0d busy_cycles=%0d cout,sum=%b, want 2 1 %b",
                     v, lat, nbusy, got, want[v]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_back_to_back();
      test_ignore_start();
      test_async_reset();
      test_width1();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
